// File: rtl/javk_bus_mem.sv
// javk_bus_mem: memory-side CPU bus responder.
// Decodes a RAM window with a write-protected low region and one status
// register. Read data is returned on the shared databus one cycle after the
// address. Rejected writes feed a saturating fault counter and a sticky flag.
module javk_bus_mem #(
   parameter logic [15:0] BASE      = 16'h0000,
   parameter int          ADDR_W    = 10,
   parameter logic [15:0] RO_TOP    = 16'h0100,
   parameter logic [15:0] STAT_ADDR = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addrbus,
   input  logic        rw,
   inout  wire  [7:0]  databus,
   output logic        sel,
   output logic        wr_fault,
   output logic        fault_sticky
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   localparam int DEPTH = 2 ** ADDR_W;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [7:0]          r_mem [DEPTH];
   logic [7:0]          r_rdata_p1;
   logic [7:0]          r_fault_cnt;
   logic                r_sel;
   logic                r_wr_fault;
   logic                r_fault_sticky;

   logic                w_ram_hit;
   logic                w_stat_hit;
   logic                w_hit;
   logic [ADDR_W-1:0]   w_ofs;
   logic                w_ofs_ro;
   logic                w_rd;
   logic                w_wr_ram_ok;
   logic                w_wr_ram_ro;
   logic                w_wr_stat;
   logic                w_drive_en;

   // Counter increment that holds at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Address decode and per-cycle transaction classification.
   always_comb begin
      w_ram_hit   = (addrbus[15:ADDR_W] == BASE[15:ADDR_W]);
      w_stat_hit  = (addrbus == STAT_ADDR);
      w_hit       = w_ram_hit | w_stat_hit;
      w_ofs       = addrbus[ADDR_W-1:0];
      w_ofs_ro    = ({{(16-ADDR_W){1'b0}}, w_ofs} < RO_TOP);
      w_rd        = w_hit & rw;
      w_wr_ram_ok = w_ram_hit & ~rw & ~w_ofs_ro;
      w_wr_ram_ro = w_ram_hit & ~rw &  w_ofs_ro;
      w_wr_stat   = w_stat_hit & ~rw;
   end

   // Next state: any hit read drives the bus in the following cycle.
   always_comb begin
      w_state_nxt = IDLE;
      if (w_rd) begin
         w_state_nxt = DRIVE;
      end
   end

   // State register; reset releases the bus immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---- stage p1: read data captured at the address edge ----
   // Read data register, refreshed on every hit read (RAM or status).
   always_ff @(posedge clk) begin
      if (w_rd) begin
         r_rdata_p1 <= w_ram_hit ? r_mem[w_ofs] : r_fault_cnt;
      end
   end

   // RAM array: only writes above the protected region land; no reset.
   always_ff @(posedge clk) begin
      if (w_wr_ram_ok) begin
         r_mem[w_ofs] <= databus;
      end
   end

   // Fault bookkeeping, registered hit and fault pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel          <= 1'b0;
         r_wr_fault     <= 1'b0;
         r_fault_sticky <= 1'b0;
         r_fault_cnt    <= 8'h00;
      end else begin
         r_sel      <= w_hit;
         r_wr_fault <= w_wr_ram_ro;
         if (w_wr_stat) begin
            r_fault_cnt    <= 8'h00;
            r_fault_sticky <= 1'b0;
         end else if (w_wr_ram_ro) begin
            r_fault_cnt    <= sat_inc(r_fault_cnt);
            r_fault_sticky <= 1'b1;
         end
      end
   end

   // Drive enable follows rw combinationally so a following write never
   // contends with the tail of a read.
   always_comb begin
      w_drive_en = (r_state == DRIVE) & rw;
   end

   assign databus      = w_drive_en ? r_rdata_p1 : 8'hzz;
   assign sel          = r_sel;
   assign wr_fault     = r_wr_fault;
   assign fault_sticky = r_fault_sticky;

endmodule

// File: tb/tb_javk_bus_mem.sv
// Bench for javk_bus_mem: directed scenarios followed by a randomized
// phase, all checked against a simple address-map model of the responder.
module tb_javk_bus_mem;

   localparam logic [15:0] BASE      = 16'h0000;
   localparam int          WIN       = 1024;
   localparam int          RO_BYTES  = 256;
   localparam logic [15:0] STAT_ADDR = 16'hFFFF;
   localparam logic [15:0] MISS_ADDR = 16'h8000;
   // A released bus floats high through the pull-ups below.
   localparam logic [7:0]  RELEASED  = 8'hFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addrbus;
   logic        rw;
   wire  [7:0]  databus;
   logic        sel;
   logic        wr_fault;
   logic        fault_sticky;

   logic        tb_drv;
   logic [7:0]  tb_wdata;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [7:0] m_mem   [WIN];
   bit         m_known [WIN];
   int         m_cnt;
   bit         m_sticky;

   always #5 clk = ~clk;

   assign databus = tb_drv ? tb_wdata : 8'hzz;

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (databus[g]);
   end

   javk_bus_mem dut (
      .clk          (clk),
      .rst          (rst),
      .addrbus      (addrbus),
      .rw           (rw),
      .databus      (databus),
      .sel          (sel),
      .wr_fault     (wr_fault),
      .fault_sticky (fault_sticky)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   function automatic bit is_ram(input logic [15:0] a);
      return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + WIN);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      addrbus = MISS_ADDR;
      rw      = 1'b1;
      tb_drv  = 1'b0;
   endtask

   // Apply one write to the model; returns whether it is a rejected write.
   task automatic model_write(input logic [15:0] a, input logic [7:0] d, output bit fault);
      int off;
      fault = 0;
      if (a == STAT_ADDR) begin
         m_cnt    = 0;
         m_sticky = 0;
      end else if (is_ram(a)) begin
         off = int'(a) - int'(BASE);
         if (off < RO_BYTES) begin
            fault    = 1;
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
         end else begin
            m_mem[off]   = d;
            m_known[off] = 1;
         end
      end
   endtask

   task automatic bus_write(input string tag, input logic [15:0] a, input logic [7:0] d);
      bit f;
      addrbus  = a;
      rw       = 1'b0;
      tb_drv   = 1'b1;
      tb_wdata = d;
      tick();
      model_write(a, d, f);
      idle();
      chk({tag, ".wr_fault"}, {7'd0, wr_fault}, {7'd0, f});
      chk({tag, ".sticky"}, {7'd0, fault_sticky}, {7'd0, m_sticky});
      chk({tag, ".sel"}, {7'd0, sel}, {7'd0, (is_ram(a) || a == STAT_ADDR)});
   endtask

   // Issue a read and check the data phase; rw stays high afterwards.
   task automatic bus_read(input string tag, input logic [15:0] a);
      bit hit;
      int off;
      addrbus = a;
      rw      = 1'b1;
      tb_drv  = 1'b0;
      tick();
      hit = is_ram(a) || (a == STAT_ADDR);
      chk({tag, ".sel"}, {7'd0, sel}, {7'd0, hit});
      chk({tag, ".wr_fault"}, {7'd0, wr_fault}, 8'd0);
      if (a == STAT_ADDR) begin
         chk({tag, ".data"}, databus, 8'(m_cnt));
      end else if (is_ram(a)) begin
         off = int'(a) - int'(BASE);
         if (m_known[off]) chk({tag, ".data"}, databus, m_mem[off]);
      end else begin
         chk({tag, ".data"}, databus, RELEASED);
      end
   endtask

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      int          op;

      rst = 1'b0;
      tb_wdata = 8'h00;
      idle();
      m_cnt = 0;
      m_sticky = 0;
      for (int i = 0; i < WIN; i++) m_known[i] = 0;
      // Backdoor preload of the protected region.
      for (int i = 0; i < RO_BYTES; i++) begin
         d = (i == 16'h0010) ? 8'h3C : 8'($urandom_range(0, 255));
         dut.r_mem[i] = d;
         m_mem[i]     = d;
         m_known[i]   = 1;
      end

      // Reset state
      tick();
      tick();
      chk("reset.sel", {7'd0, sel}, 8'd0);
      chk("reset.wr_fault", {7'd0, wr_fault}, 8'd0);
      chk("reset.sticky", {7'd0, fault_sticky}, 8'd0);
      chk("reset.bus", databus, RELEASED);
      #2 rst = 1'b1;

      // Write / readback, then release when rw drops
      bus_write("wr_a5", BASE + 16'h0200, 8'hA5);
      bus_read("rd_a5", BASE + 16'h0200);
      addrbus = MISS_ADDR;
      rw      = 1'b0;
      #1;
      chk("release_after_read", databus, RELEASED);
      tick();
      idle();

      // Protected write
      bus_write("prot_wr", BASE + 16'h0010, 8'hFF);
      tick();
      chk("prot_pulse_end", {7'd0, wr_fault}, 8'd0);
      bus_read("prot_rd", BASE + 16'h0010);
      bus_read("stat_one", STAT_ADDR);

      // Saturation and clear
      for (int i = 0; i < 300; i++) begin
         bus_write("sat_wr", BASE + 16'($urandom_range(0, RO_BYTES - 1)), 8'($urandom_range(0, 255)));
      end
      bus_read("stat_sat", STAT_ADDR);
      bus_write("stat_clr", STAT_ADDR, 8'h00);
      bus_read("stat_zero", STAT_ADDR);

      // Turnaround: read immediately followed by a bench-driven write
      bus_write("ta_pre", 16'h0300, 8'h12);
      bus_read("ta_rd", 16'h0300);
      addrbus  = 16'h0301;
      rw       = 1'b0;
      tb_drv   = 1'b1;
      tb_wdata = 8'h77;
      #1;
      chk("ta_no_x", {7'd0, $isunknown(databus)}, 8'd0);
      chk("ta_bus", databus, 8'h77);
      begin
         bit f;
         tick();
         model_write(16'h0301, 8'h77, f);
         chk("ta_wr_fault", {7'd0, wr_fault}, {7'd0, f});
      end
      idle();
      bus_read("ta_rb", 16'h0301);

      // Miss
      bus_read("miss_rd", MISS_ADDR);
      bus_write("miss_wr", MISS_ADDR, 8'h55);
      bus_read("miss_cnt", STAT_ADDR);

      // Reset mid-read
      bus_write("rr_prot", BASE + 16'h0020, 8'h01);
      bus_read("rr_rd", BASE + 16'h0200);
      #2 rst = 1'b0;
      #1;
      m_cnt = 0;
      m_sticky = 0;
      chk("rr.bus", databus, RELEASED);
      chk("rr.sel", {7'd0, sel}, 8'd0);
      chk("rr.wr_fault", {7'd0, wr_fault}, 8'd0);
      chk("rr.sticky", {7'd0, fault_sticky}, 8'd0);
      idle();
      tick();
      #2 rst = 1'b1;
      bus_read("rr_ram_kept", BASE + 16'h0200);
      bus_read("rr_cnt", STAT_ADDR);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            bus_read("rnd_rd", BASE + 16'($urandom_range(0, WIN - 1)));
         end else if (op <= 6) begin
            bus_write("rnd_wr", BASE + 16'($urandom_range(0, WIN - 1)), 8'($urandom_range(0, 255)));
         end else if (op == 7) begin
            bus_read("rnd_stat", STAT_ADDR);
         end else if (op == 8) begin
            a = 16'($urandom_range(16'h0400, 16'hFFFE));
            if ($urandom_range(0, 1) == 1) bus_read("rnd_miss_rd", a);
            else bus_write("rnd_miss_wr", a, 8'($urandom_range(0, 255)));
         end else begin
            bus_write("rnd_stat_wr", STAT_ADDR, 8'($urandom_range(0, 255)));
         end
      end
      bus_read("final_stat", STAT_ADDR);
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
